// File: rtl/waveform_conditioner.sv
// Tone front end: synchronise, glitch-filter and edge-detect a raw square wave; measure rise-to-rise period and flag silence.
// Latency: waveform_in to waveform_clean is 2+GLITCH_CYCLES cycles; period_valid follows the accepting rise_pulse by one cycle.
// Backpressure: none, this is a free-running stream stage and every output is a level or a one-cycle strobe.
module waveform_conditioner #(
  parameter int GLITCH_CYCLES  = 16,
  parameter int PERIOD_W       = 24,
  parameter int MIN_PERIOD     = 50000,
  parameter int SILENCE_CYCLES = 4000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                waveform_in,
  output logic                waveform_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                silent
);

  // Tracking states: IDLE has no reference rise, ARMED has one but no
  // accepted period yet, TRACKING has produced at least one period.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_TRACKING = 2'd2;

  // Glitch counter is 8 bits wide because GLITCH_CYCLES never exceeds 255.
  localparam logic [7:0]          GC_LAST = 8'(GLITCH_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] SIL_P   = PERIOD_W'(SILENCE_CYCLES);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                clean_q, clean_d;
  logic [7:0]          gc_q, gc_d;
  logic                prev_q, prev_d;
  logic                rise, fall;
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                silent_q, silent_d;
  logic                long_enough;

  // Two-flop synchroniser; only the second stage is ever looked at.
  always_comb begin
    sync1_d = waveform_in;
    sync2_d = sync1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Glitch filter: the clean level only follows sync2 after GLITCH_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    gc_d    = gc_q;
    clean_d = clean_q;
    if (sync2_q == clean_q) begin
      gc_d = 8'd0;
    end else if (gc_q == GC_LAST) begin
      clean_d = sync2_q;
      gc_d    = 8'd0;
    end else begin
      gc_d = gc_q + 8'd1;
    end
  end

  // Glitch filter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gc_q    <= 8'd0;
      clean_q <= 1'b0;
    end else begin
      gc_q    <= gc_d;
      clean_q <= clean_d;
    end
  end

  // Edge detect against a one-cycle-old copy of the clean level; the two
  // pulses are mutually exclusive because they need opposite clean values.
  always_comb begin
    prev_d = clean_q;
    rise   = clean_q & ~prev_q;
    fall   = ~clean_q & prev_q;
  end

  // Previous-level register for the edge detector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A rise closes the current measurement; the period equals cnt_q at that
  // moment because cnt restarts at 1 on the cycle after each rise.
  assign long_enough = (cnt_q >= MIN_P);

  // Period tracker. A rise takes priority over the silence timeout, so a
  // rise landing exactly on SILENCE_CYCLES is still measured and accepted.
  // cnt stops at SILENCE_CYCLES, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    silent_d = silent_q;
    case (state_q)
      ST_IDLE: begin
        silent_d = 1'b1;
        cnt_d    = '0;
        if (rise) begin
          state_d = ST_ARMED;
          cnt_d   = CNT_ONE;
        end
      end
      ST_ARMED, ST_TRACKING: begin
        if (rise) begin
          cnt_d = CNT_ONE;
          if (long_enough) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            silent_d = 1'b0;
            state_d  = ST_TRACKING;
          end
        end else if (cnt_q == SIL_P) begin
          // Tone lost: keep the last period for debug, no strobe.
          state_d  = ST_IDLE;
          cnt_d    = '0;
          silent_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        silent_d = 1'b1;
      end
    endcase
  end

  // Period tracker registers; reset drops any partial measurement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      silent_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      silent_q <= silent_d;
    end
  end

  assign waveform_clean = clean_q;
  assign rise_pulse     = rise;
  assign fall_pulse     = fall;
  assign period_out     = period_q;
  assign period_valid   = pv_q;
  assign silent         = silent_q;

endmodule

// File: tb/tb_waveform_conditioner.sv
// Bench for waveform_conditioner with scaled-down period parameters.
// Each clock is checked against a cycle-level reference model, plus directed checks on counts and values.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_waveform_conditioner;

  localparam int GC   = 16;
  localparam int PW   = 12;
  localparam int MINP = 200;
  localparam int SIL  = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          waveform_in = 1'b0;
  logic          waveform_clean, rise_pulse, fall_pulse, period_valid, silent;
  logic [PW-1:0] period_out;

  int errors = 0;
  int checks = 0;

  waveform_conditioner #(
    .GLITCH_CYCLES (GC),
    .PERIOD_W      (PW),
    .MIN_PERIOD    (MINP),
    .SILENCE_CYCLES(SIL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .waveform_in   (waveform_in),
    .waveform_clean(waveform_clean),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .period_out    (period_out),
    .period_valid  (period_valid),
    .silent        (silent)
  );

  always #5 clk = ~clk;

  // Reference model: the clean level flips when the last GC synchronised
  // samples all disagree with it; period and silence come from timestamps
  // of the rises.
  logic          m_s1 = 0, m_s2 = 0, m_clean = 0, m_prev = 0, m_pv = 0, m_silent = 1;
  logic [GC-1:0] m_win = '0;
  logic [PW-1:0] m_pout = '0;
  bit            m_have_ref = 0;
  int            m_ref_t = 0;
  int            cyc = 0;

  // Observation counters for directed checks.
  int nstep = 0, n_pv = 0, n_rise = 0, n_fall = 0, last_rise_step = 0;
  int pv_min = 0, pv_max = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic old_rise;
    if (!reset) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_prev = 0; m_win = '0;
      m_pv = 0; m_pout = '0; m_silent = 1; m_have_ref = 0;
    end else begin
      old_rise = m_clean & ~m_prev;
      m_pv = 0;
      if (old_rise) begin
        if (m_have_ref && (cyc - m_ref_t) >= MINP) begin
          m_pout   = PW'(cyc - m_ref_t);
          m_pv     = 1;
          m_silent = 0;
        end
        m_have_ref = 1;
        m_ref_t    = cyc;
      end else if (m_have_ref && (cyc - m_ref_t) == SIL) begin
        m_have_ref = 0;
        m_silent   = 1;
      end
      m_prev = m_clean;
      m_win  = {m_win[GC-2:0], m_s2};
      if (m_win == {GC{~m_clean}}) m_clean = ~m_clean;
      m_s2 = m_s1;
      m_s1 = waveform_in;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("clean", waveform_clean, m_clean);
    check("rise", rise_pulse, m_clean & ~m_prev);
    check("fall", fall_pulse, ~m_clean & m_prev);
    check("period_out", period_out, m_pout);
    check("period_valid", period_valid, m_pv);
    check("silent", silent, m_silent);
    nstep++;
    if (period_valid === 1'b1) begin
      n_pv++;
      if (int'(period_out) < pv_min) pv_min = int'(period_out);
      if (int'(period_out) > pv_max) pv_max = int'(period_out);
    end
    if (rise_pulse === 1'b1) begin
      n_rise++;
      last_rise_step = nstep;
    end
    if (fall_pulse === 1'b1) n_fall++;
  endtask

  task automatic clear_counts();
    n_pv = 0; n_rise = 0; n_fall = 0; pv_min = 1 << 30; pv_max = 0;
  endtask

  task automatic hold(input logic lvl, input int n);
    waveform_in = lvl;
    repeat (n) step();
  endtask

  task automatic tone(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
  endtask

  initial begin
    bit   seen;
    logic lvl;
    int   len;
    clear_counts();

    // Reset held 3 cycles while the input toggles.
    for (int i = 0; i < 3; i++) begin
      waveform_in = ~waveform_in;
      step();
    end
    check("rst_clean", waveform_clean, 1'b0);
    check("rst_silent", silent, 1'b1);
    check("rst_period", period_out, 0);
    check("rst_pv", period_valid, 1'b0);
    reset = 1'b1;
    waveform_in = 1'b1;
    repeat (17) step();
    check("latency_before", waveform_clean, 1'b0);
    step();
    check("latency_at18", waveform_clean, 1'b1);
    check("latency_rise", rise_pulse, 1'b1);
    hold(1'b1, 20);
    hold(1'b0, 40);

    // Glitch rejection: 10-cycle pulse vanishes, 20-cycle pulse passes.
    clear_counts();
    hold(1'b1, 10);
    hold(1'b0, 40);
    check("glitch_rise", n_rise, 0);
    check("glitch_fall", n_fall, 0);
    check("glitch_clean", waveform_clean, 1'b0);
    waveform_in = 1'b1;
    repeat (17) step();
    check("pulse20_before", waveform_clean, 1'b0);
    step();
    check("pulse20_clean", waveform_clean, 1'b1);
    check("pulse20_rise", rise_pulse, 1'b1);
    hold(1'b1, 2);
    hold(1'b0, 40);
    check("pulse20_nrise", n_rise, 1);
    check("pulse20_nfall", n_fall, 1);

    // Steady tone: 6 periods of 300 give 5 strobes of 300.
    do_reset(2);
    clear_counts();
    tone(150, 150, 6);
    hold(1'b0, 50);
    check("tone_nrise", n_rise, 6);
    check("tone_npv", n_pv, 5);
    check("tone_pmin", pv_min, 300);
    check("tone_pmax", pv_max, 300);
    check("tone_silent", silent, 1'b0);

    // Periods below MIN_PERIOD are ignored; then 250-cycle periods accepted.
    do_reset(2);
    clear_counts();
    tone(75, 75, 5);
    check("short_npv", n_pv, 0);
    check("short_silent", silent, 1'b1);
    tone(125, 125, 3);
    hold(1'b0, 30);
    check("long_npv", n_pv, 2);
    check("long_pmin", pv_min, 250);
    check("long_pmax", pv_max, 250);
    check("long_silent", silent, 1'b0);

    // Silence timeout after the tone stops; period_out keeps its value.
    do_reset(2);
    clear_counts();
    tone(150, 150, 4);
    waveform_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (silent === 1'b1) seen = 1;
    end
    check("sil_seen", silent, 1'b1);
    // Silence is visible SIL edges after the edge that ends the rise_pulse cycle.
    check("sil_delay", nstep - last_rise_step, SIL + 1);
    check("sil_period", period_out, 300);
    check("sil_npv", n_pv, 3);
    tone(150, 150, 1);
    check("rearm_npv", n_pv, 3);
    check("rearm_silent", silent, 1'b1);
    tone(150, 150, 1);
    check("rearm2_npv", n_pv, 4);
    check("rearm2_silent", silent, 1'b0);

    // Reset while tracking clears everything and forces a fresh arm.
    do_reset(1);
    check("midrst_period", period_out, 0);
    check("midrst_silent", silent, 1'b1);
    clear_counts();
    tone(150, 150, 1);
    check("midrst_npv1", n_pv, 0);
    tone(150, 150, 1);
    hold(1'b0, 30);
    check("midrst_npv2", n_pv, 1);
    check("midrst_pval", pv_max, 300);

    // Random levels, glitches and occasional resets against the model.
    lvl = 1'b0;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      lvl = ~lvl;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 20);
      else len = $urandom_range(20, 400);
      hold(lvl, len);
    end
    hold(1'b0, 1200);
    check("rand_end_silent", silent, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
